right_shift: RTL and testbench
==============================

Name: right_shift

Overview:
- Registered logical right shifter for FPU mantissa alignment. Used to align the smaller operand's fraction before add/subtract.
- Takes a 25-bit fraction (hidden bit plus 23 fraction bits plus 1 guard/carry bit) and an 8-bit shift amount, which is an exponent difference.
- Produces the zero-filled shifted fraction one clock later.
- Sits between the exponent-compare stage and the mantissa adder.

Parameters:
- WIDTH, 25, fraction/result width in bits.
- SHIFT_W, 8, shift_amount width in bits; full unsigned range 0..2^SHIFT_W-1 accepted.

Ports:
- CLK  input  1  rising-edge clock.
- nRST  input  1  asynchronous active-low reset.
- in_valid  input  1  fraction/shift_amount valid this cycle.
- fraction  input  WIDTH  unsigned fraction to shift.
- shift_amount  input  SHIFT_W  unsigned right-shift distance.
- out_valid  output  1  result valid; registered in_valid.
- result  output  WIDTH  fraction >> shift_amount, zero-filled, registered.

Behaviour:
- Reset: nRST low asynchronously forces result=0 and out_valid=0 (plus sticky=0 when the optional feature is built). These values hold while nRST is low.
- Latency: exactly 1 cycle. Inputs sampled on a CLK rising edge with in_valid=1 appear on result at that same edge; out_valid=1 for that cycle.
- in_valid=0 at an edge: out_valid goes 0 at that edge and result holds its previous value. No back-pressure, no ready signal; a new operation is accepted every cycle (throughput 1/cycle).
- Shift rule: logical right shift.
  - result[i] = fraction[i+shift_amount] for i+shift_amount <= WIDTH-1, else 0.
  - MSBs are zero-filled; there is no sign extension.
- shift_amount = 0: result = fraction unchanged.
- shift_amount >= WIDTH (25..255): result = 0. There is no wrap and no modulo of the shift amount.
- Implementation: log2 barrel structure with stages 1, 2, 4, 8, 16, plus an "overflow" detect on shift_amount >= WIDTH that forces 0. Combinational, followed by a single output register.
- Reset mid-stream: an operation in flight is discarded. The first post-reset edge with in_valid=1 behaves normally.
- Inputs with X are not required to be handled; the design must be fully specified for all 2^(WIDTH+SHIFT_W) input combinations.

Optional Feature:
- Macro: RIGHT_SHIFT_STICKY_EN.
- Defined:
  - Adds output port sticky (1 bit, registered alongside result, same latency and reset value 0).
  - sticky = OR of all fraction bits shifted out below bit 0.
  - For shift_amount >= WIDTH, sticky = |fraction.
  - For shift_amount = 0, sticky = 0.
- Not defined: port absent; no sticky logic synthesized; all other behaviour identical.

Decomposition:
- Shared FPU package (fpu_pkg): constants FRAC_W=25 and EXP_W=8; typedef frac_t (logic [FRAC_W-1:0]); typedef exp_diff_t (logic [EXP_W-1:0]).
- One natural sub-module: right_shift_comb, the purely combinational barrel shifter (plus sticky when enabled). It is instantiated once inside the registered wrapper.

Test Plan:
- Reset: nRST=0 with any inputs -> result=0x0000000, out_valid=0 immediately (asynchronously, no clock edge needed).
- fraction=0x0100000 (2^20), in_valid=1, sweep shift_amount=0..229 one per cycle -> each result one cycle later:
  - shift 0 -> 0x0100000
  - shift 4 -> 0x0010000
  - shift 20 -> 0x0000001
  - shift 21..229 -> 0x0000000
- fraction=0x1F00000 (bits 24:20 set), shift 20 -> result 0x000001F; shift 24 -> 0x0000001; shift 25 -> 0x0000000.
- Boundary: fraction=0x1FFFFFF, shift 255 -> result 0; shift 0 -> 0x1FFFFFF. With RIGHT_SHIFT_STICKY_EN: shift 255 -> sticky=1; shift 0 -> sticky=0; fraction=0x0000003, shift 1 -> result 0x0000001, sticky=1.
- Handshake:
  - Back-to-back in_valid=1 for 3 cycles (distinct values) -> 3 consecutive out_valid=1 cycles with matching results.
  - in_valid drops to 0 -> out_valid=0 next edge and result holds.
- Reset mid-operation: assert nRST=0 in the cycle after an in_valid=1 edge -> out_valid and result clear at once. After release, the first valid op returns its correct result one cycle later.

Source files
------------

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared FPU widths and types used by the mantissa datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  localparam int FRAC_W = 25;
  localparam int EXP_W  = 8;

  typedef logic [FRAC_W-1:0] frac_t;
  typedef logic [EXP_W-1:0]  exp_diff_t;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/right_shift_comb.sv
`default_nettype none
// ============================================================================
// Module      : right_shift_comb
// Description : Combinational log2 barrel right shifter, zero-filled; shift
//               distances >= WIDTH give zero. RIGHT_SHIFT_STICKY_EN adds a
//               sticky output (OR of all bits shifted out).
// Revision    : 1.0 - initial release
// ============================================================================
module right_shift_comb #(
  parameter int WIDTH   = 25,
  parameter int SHIFT_W = 8
) (
  input  logic [WIDTH-1:0]   fraction,
  input  logic [SHIFT_W-1:0] shift_amount,
`ifdef RIGHT_SHIFT_STICKY_EN
  output logic               sticky,
`endif
  output logic [WIDTH-1:0]   result
);

  localparam int NSTAGE = $clog2(WIDTH);

  logic [WIDTH-1:0] stg [NSTAGE+1];
  logic             overflow;

  assign stg[0]   = fraction;
  // The stages only see the low NSTAGE bits; anything reaching WIDTH or
  // beyond is caught here so there is no modulo wrap.
  assign overflow = 32'(shift_amount) >= 32'(WIDTH);

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int S = 1 << k;
    assign stg[k+1] = shift_amount[k] ? {{S{1'b0}}, stg[k][WIDTH-1:S]} : stg[k];
  end

  assign result = overflow ? '0 : stg[NSTAGE];

`ifdef RIGHT_SHIFT_STICKY_EN
  logic stk [NSTAGE+1];

  assign stk[0] = 1'b0;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_sticky
    localparam int S = 1 << k;
    assign stk[k+1] = stk[k] | (shift_amount[k] & (|stg[k][S-1:0]));
  end

  assign sticky = overflow ? (|fraction) : stk[NSTAGE];
`endif

endmodule : right_shift_comb
`default_nettype wire

// File: rtl/right_shift.sv
`default_nettype none
// ============================================================================
// Module      : right_shift
// Description : Registered mantissa-alignment right shifter, 1-cycle latency.
//               Optional sticky output under RIGHT_SHIFT_STICKY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module right_shift
  import fpu_pkg::*;
#(
  parameter int WIDTH   = FRAC_W,
  parameter int SHIFT_W = EXP_W
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   fraction,
  input  logic [SHIFT_W-1:0] shift_amount,
`ifdef RIGHT_SHIFT_STICKY_EN
  output logic               sticky,
`endif
  output logic               out_valid,
  output logic [WIDTH-1:0]   result
);

  logic [WIDTH-1:0] shifted;
`ifdef RIGHT_SHIFT_STICKY_EN
  logic             shifted_sticky;
`endif

  right_shift_comb #(
    .WIDTH   (WIDTH),
    .SHIFT_W (SHIFT_W)
  ) u_comb (
    .fraction     (fraction),
    .shift_amount (shift_amount),
`ifdef RIGHT_SHIFT_STICKY_EN
    .sticky       (shifted_sticky),
`endif
    .result       (shifted)
  );

  // Result (and sticky) hold their last value on idle cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid <= 1'b0;
      result    <= '0;
`ifdef RIGHT_SHIFT_STICKY_EN
      sticky    <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= shifted;
`ifdef RIGHT_SHIFT_STICKY_EN
        sticky <= shifted_sticky;
`endif
      end
    end
  end

endmodule : right_shift
`default_nettype wire

// File: tb/tb_right_shift.sv
`default_nettype none
// ============================================================================
// Module      : tb_right_shift
// Description : Directed, table-driven self-checking bench for right_shift.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_right_shift;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        in_valid = 1'b0;
  logic [24:0] fraction = '0;
  logic [7:0]  shift_amount = '0;
  logic        out_valid;
  logic [24:0] result;
`ifdef RIGHT_SHIFT_STICKY_EN
  logic        sticky;
`endif

  int errors = 0;
  int checks = 0;

  right_shift dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_valid     (in_valid),
    .fraction     (fraction),
    .shift_amount (shift_amount),
`ifdef RIGHT_SHIFT_STICKY_EN
    .sticky       (sticky),
`endif
    .out_valid    (out_valid),
    .result       (result)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [24:0] frac;
    logic [7:0]  sh;
    logic [24:0] res;
    logic        stk;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%07h expected 0x%07h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [24:0] f, input logic [7:0] s);
    @(negedge CLK);
    in_valid     = v;
    fraction     = f;
    shift_amount = s;
  endtask

  task automatic step_check(input string name, input logic [24:0] exp_r,
                            input logic exp_v, input logic exp_s);
    @(posedge CLK);
    #1;
    check({name, ".valid"}, 32'(out_valid), 32'(exp_v));
    check({name, ".result"}, 32'(result), 32'(exp_r));
`ifdef RIGHT_SHIFT_STICKY_EN
    check({name, ".sticky"}, 32'(sticky), 32'(exp_s));
`else
    if (exp_s) begin end
`endif
  endtask

  initial begin
    logic [24:0] exp_r;

    vecs[0]  = '{25'h1F00000, 8'd20,  25'h000001F, 1'b0};
    vecs[1]  = '{25'h1F00000, 8'd24,  25'h0000001, 1'b1};
    vecs[2]  = '{25'h1F00000, 8'd25,  25'h0000000, 1'b1};
    vecs[3]  = '{25'h1FFFFFF, 8'd255, 25'h0000000, 1'b1};
    vecs[4]  = '{25'h1FFFFFF, 8'd0,   25'h1FFFFFF, 1'b0};
    vecs[5]  = '{25'h0000003, 8'd1,   25'h0000001, 1'b1};
    vecs[6]  = '{25'h0000000, 8'd255, 25'h0000000, 1'b0};
    vecs[7]  = '{25'h1FFFFFF, 8'd24,  25'h0000001, 1'b1};
    vecs[8]  = '{25'h1FFFFFF, 8'd31,  25'h0000000, 1'b1};
    vecs[9]  = '{25'h1ABCDEF, 8'd8,   25'h001ABCD, 1'b1};
    vecs[10] = '{25'h1000001, 8'd1,   25'h0800000, 1'b1};
    vecs[11] = '{25'h0AAAAAA, 8'd3,   25'h0155555, 1'b1};
    vecs[12] = '{25'h1234560, 8'd4,   25'h0123456, 1'b0};
    vecs[13] = '{25'h1FFFFFF, 8'd16,  25'h00001FF, 1'b1};
    vecs[14] = '{25'h1FFFFFF, 8'd128, 25'h0000000, 1'b1};
    vecs[15] = '{25'h1800000, 8'd32,  25'h0000000, 1'b1};

    // Asynchronous reset: outputs clear before any clock edge.
    #2 nRST = 1'b0;
    in_valid = 1'b1; fraction = 25'h1FFFFFF; shift_amount = 8'd0;
    #1;
    check("reset.valid", 32'(out_valid), 32'd0);
    check("reset.result", 32'(result), 32'd0);
    step_check("reset_hold", 25'h0, 1'b0, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    in_valid = 1'b0;

    // Sweep a single set bit across every shift distance up to 229.
    for (int s = 0; s <= 229; s++) begin
      exp_r = (s < 25) ? 25'(32'h0100000 >> s) : 25'h0;
      drive(1'b1, 25'h0100000, 8'(s));
      step_check($sformatf("sweep%0d", s), exp_r, 1'b1, s > 20);
    end

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].frac, vecs[i].sh);
      step_check($sformatf("vec%0d", i), vecs[i].res, 1'b1, vecs[i].stk);
    end

    // Back-to-back operations followed by an idle cycle that must hold.
    drive(1'b1, 25'h0000F00, 8'd4);
    step_check("b2b0", 25'h00000F0, 1'b1, 1'b0);
    drive(1'b1, 25'h0000F00, 8'd8);
    step_check("b2b1", 25'h000000F, 1'b1, 1'b0);
    drive(1'b1, 25'h0000F00, 8'd10);
    step_check("b2b2", 25'h0000003, 1'b1, 1'b1);
    drive(1'b0, 25'h1FFFFFF, 8'd0);
    step_check("idle0", 25'h0000003, 1'b0, 1'b1);
    drive(1'b0, 25'h0000000, 8'd1);
    step_check("idle1", 25'h0000003, 1'b0, 1'b1);

    // Reset in the cycle after a valid edge discards the result at once.
    drive(1'b1, 25'h1FFFFFF, 8'd1);
    step_check("pre_rst", 25'h0FFFFFF, 1'b1, 1'b1);
    #2 nRST = 1'b0;
    #1;
    check("midrst.valid", 32'(out_valid), 32'd0);
    check("midrst.result", 32'(result), 32'd0);
`ifdef RIGHT_SHIFT_STICKY_EN
    check("midrst.sticky", 32'(sticky), 32'd0);
`endif
    step_check("midrst_hold", 25'h0, 1'b0, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    fraction = 25'h0ABCDE0; shift_amount = 8'd5; in_valid = 1'b1;
    step_check("post_rst", 25'h0055E6F, 1'b1, 1'b0);
    drive(1'b0, 25'h0, 8'd0);
    step_check("post_rst_idle", 25'h0055E6F, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_right_shift
`default_nettype wire
